// File: rtl/vector_accumulator.sv
// rtl/vector_accumulator.sv - sums each group of VEC_LEN signed words into one held vector result
//
// Purpose
//   Sits behind the 2-cycle word delay stage. It takes signed DATA_W-bit words over a
//   valid/ready handshake and adds up each run of VEC_LEN accepted words. Each result is
//   sign-extended to ACC_W bits and is held on out_sum with its own valid/ready handshake.
//   Only one vector is in flight at a time. While a result waits for the consumer, no new
//   word is accepted.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   clear      in   1       synchronous abort of the partial or held vector (top priority)
//   in_valid   in   1       in_data is valid
//   in_data    in   DATA_W  signed input word
//   in_ready   out  1       a word is accepted this cycle when in_valid is also high
//   out_valid  out  1       out_sum holds a completed vector sum
//   out_sum    out  ACC_W   signed vector sum
//   out_ready  in   1       consumer takes out_sum (ignored while out_valid is low)
//   count      out  8       words accepted so far in the current vector (0..VEC_LEN-1)
//   busy       out  1       a vector is being accumulated or its result is held
//
// Configuration
//   ACC_SAT_EN  when defined, each addition clamps to the signed ACC_W range instead of
//               wrapping. The ports are the same in both builds.

module vector_accumulator #(
    parameter int DATA_W  = 32,
    parameter int VEC_LEN = 8,
    parameter int ACC_W   = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_sum,
    input  logic              out_ready,
    output logic [7:0]        count,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Index of the final word of a vector. The count register is 8 bits wide, so
    // VEC_LEN = 256 still fits because count only runs from 0 to 255.
    localparam logic [7:0] LAST_IDX = 8'(VEC_LEN - 1);

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] word_ext;
    logic [ACC_W-1:0] add_base;
    logic [ACC_W-1:0] sum_next;
    logic             accept;

    // Ready is held low during reset, while a result is held, and in a clear cycle.
    // A word presented in a clear cycle is therefore never accepted.
    assign in_ready = rst_n & ~clear & (state != ST_DONE);
    assign accept   = in_valid & in_ready;
    assign busy     = (state != ST_IDLE);

    assign word_ext = ACC_W'($signed(in_data));

    // The first word of a vector starts from zero rather than from the previous acc.
    // This way IDLE and ACCUM share one adder, and a fresh vector cannot overflow.
    assign add_base = (state == ST_IDLE) ? '0 : acc;

`ifdef ACC_SAT_EN
    logic [ACC_W-1:0] raw_sum;
    logic             ovf;

    assign raw_sum = add_base + word_ext;

    // Overflow occurs only when both operands have the same sign and the result's
    // sign differs from it. The clamp then follows the operand sign. A later
    // opposite-sign word adds normally, so the value moves back in from the clamp.
    assign ovf = (add_base[ACC_W-1] == word_ext[ACC_W-1])
              && (raw_sum[ACC_W-1] != add_base[ACC_W-1]);

    always_comb begin
        sum_next = raw_sum;
        if (ovf) begin
            sum_next = add_base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    // Plain modulo-2^ACC_W addition.
    assign sum_next = add_base + word_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            count     <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            // out_sum is left as is. Without out_valid it carries no meaning.
            state     <= ST_IDLE;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc   <= sum_next;
                        count <= 8'd1;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        if (count == LAST_IDX) begin
                            out_sum   <= sum_next;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            count     <= '0;
                            state     <= ST_DONE;
                        end else begin
                            acc   <= sum_next;
                            count <= count + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    // in_ready is low here, so the handshake cycle never also takes a
                    // word. A pending word is taken in the following IDLE cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    acc       <= '0;
                    count     <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_accumulator.sv
// tb/tb_vector_accumulator.sv - self-checking bench for vector_accumulator

module tb_vector_accumulator;

    localparam int VLEN = 8;
`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [39:0] out_sum;
    logic        out_ready;
    logic [7:0]  count;
    logic        busy;

    logic        clear2;
    logic        in_valid2;
    logic [31:0] in_data2;
    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_sum2;
    logic        out_ready2;
    logic [7:0]  count2;
    logic        busy2;

    always #5 clk = ~clk;

    vector_accumulator #(.DATA_W(32), .VEC_LEN(VLEN), .ACC_W(40)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_sum(out_sum),
        .out_ready(out_ready), .count(count), .busy(busy)
    );

    vector_accumulator #(.DATA_W(32), .VEC_LEN(VLEN), .ACC_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .clear(clear2), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_sum(out_sum2),
        .out_ready(out_ready2), .count(count2), .busy(busy2)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: the words accepted into the current vector, and the
    // completed result the consumer has not yet taken.
    longint      m_words[$];
    bit          m_hold;
    logic [39:0] m_sum;
    logic [63:0] cap_sum;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sum of a vector, computed one word at a time in wide signed arithmetic. The
    // result is then wrapped modulo 2^aw, or with sat set, clamped after every add.
    function automatic logic [63:0] ref_sum(input longint w[$], input int aw, input bit sat);
        longint acc = 0;
        longint hi  = (longint'(1) <<< (aw - 1)) - 1;
        longint lo  = -(longint'(1) <<< (aw - 1));
        longint md  = longint'(1) <<< aw;
        foreach (w[i]) begin
            acc = acc + w[i];
            if (sat) begin
                if (acc > hi) acc = hi;
                if (acc < lo) acc = lo;
            end else begin
                acc = acc % md;
                if (acc > hi) acc = acc - md;
                if (acc < lo) acc = acc + md;
            end
        end
        return 64'(acc) & ((64'd1 << aw) - 64'd1);
    endfunction

    // Runs one clock cycle on the main DUT. It drives the inputs, checks every output
    // against the model, and then advances the model across the rising edge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic c);
        in_valid = v; in_data = d; out_ready = r; clear = c;
        #1;
        chk("in_ready",  64'(in_ready),  64'(!m_hold && !c));
        chk("out_valid", 64'(out_valid), 64'(m_hold));
        chk("count",     64'(count),     64'(m_words.size()));
        chk("busy",      64'(busy),      64'(m_hold || (m_words.size() != 0)));
        if (m_hold) chk("out_sum", 64'(out_sum), 64'(m_sum));
        if (out_valid === 1'b1) cap_sum = 64'(out_sum);
        @(posedge clk);
        if (c) begin
            m_words.delete();
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (r) m_hold = 1'b0;
        end else if (v) begin
            m_words.push_back(longint'($signed(d)));
            if (m_words.size() == VLEN) begin
                m_sum  = 40'(ref_sum(m_words, 40, SAT));
                m_hold = 1'b1;
                m_words.delete();
            end
        end
        @(negedge clk);
    endtask

    // Feeds one vector into the 32-bit accumulator instance and returns its result,
    // with a bound on every wait.
    task automatic run32(input longint w[$], input logic [31:0] exp, input string tag);
        int guard;
        logic [31:0] got;
        foreach (w[i]) begin
            in_valid2 = 1'b1; in_data2 = 32'(w[i]); out_ready2 = 1'b0;
            guard = 0;
            #1;
            while (in_ready2 !== 1'b1 && guard < 20) begin
                @(negedge clk); #1; guard++;
            end
            @(posedge clk); @(negedge clk);
        end
        in_valid2 = 1'b0;
        guard = 0;
        #1;
        while (out_valid2 !== 1'b1 && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        chk({tag, "_valid"}, 64'(out_valid2), 64'd1);
        got = out_sum2;
        out_ready2 = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready2 = 1'b0;
        chk(tag, 64'(got), 64'(exp));
    endtask

    initial begin
        longint w32[$];
        int n;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        clear2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
        m_hold = 1'b0; m_sum = '0; cap_sum = '0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum",   64'(out_sum),   64'd0);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // 1: words 1..8 back to back
        for (int i = 1; i <= 8; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t1_sum", cap_sum, 64'd36);

        // 2: 8 x (-5) with random valid gaps
        n = 0;
        while (n < 8) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            cycle(v, 32'hFFFF_FFFB, 1'b1, 1'b0);
            if (v) n++;
        end
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t2_sum", cap_sum, 64'hFF_FFFF_FFD8);

        // 3: consumer stalls for 5 cycles while a word is pending
        for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, 32'd99, 1'b0, 1'b0);
        cycle(1'b1, 32'd99, 1'b1, 1'b0);
        cycle(1'b1, 32'd99, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, $urandom, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

        // 4: clear after 3 words (with a word on the bus), then 8 x 2
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'd1000, 1'b1, 1'b0);
        cycle(1'b1, 32'd77, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'd2, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t4_sum", cap_sum, 64'd16);

        // 4b: asynchronous reset pulse in the middle of a vector
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'd5, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_count",     64'(count),     64'd0);
        chk("arst_busy",      64'(busy),      64'd0);
        chk("arst_out_sum",   64'(out_sum),   64'd0);
        m_words.delete(); m_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 6: 8 x most-negative word, exact in 40 bits
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h8000_0000, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t6_sum", cap_sum, 64'hFC_0000_0000);

        // Random traffic: data, valid gaps, back-pressure, occasional clear
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 40) == 0));
        end
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

        // 5: 32-bit accumulator, 8 x 0x7FFFFFFF (wraps, or clamps in the saturating build)
        w32.delete();
        for (int i = 0; i < 8; i++) w32.push_back(64'sh7FFF_FFFF);
        run32(w32, SAT ? 32'h7FFF_FFFF : 32'(8 * 64'h7FFF_FFFF), "t5_max");
        // Overflow followed by opposite-sign words
        w32.delete();
        for (int i = 0; i < 4; i++) w32.push_back(64'sh7FFF_FFFF);
        for (int i = 0; i < 4; i++) w32.push_back(-64'sd1);
        run32(w32, 32'(ref_sum(w32, 32, SAT)), "t5_back");
        chk("t5_idle", 64'(busy2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
